// File: rtl/pe_relay_pkg.sv
// Shared constants and FSM state type for the NSEW relay PE.
`timescale 1ns/1ps
package pe_relay_pkg;

  localparam int CH_EAST  = 0;
  localparam int CH_WEST  = 1;
  localparam int CH_NORTH = 2;
  localparam int CH_SOUTH = 3;

  localparam logic MODE_STRAIGHT = 1'b0;
  localparam logic MODE_CROSS    = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/pe_relay_fifo.sv
// Synchronous FIFO with registered storage; head reads as zero while empty.
`timescale 1ns/1ps
module pe_relay_fifo #(
  parameter int DATA_WIDTH = 130,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_push,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_pop,
  output logic [DATA_WIDTH-1:0] o_head,
  output logic                  o_empty,
  output logic                  o_full
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [AW:0]           r_wr_ptr;
  logic [AW:0]           r_rd_ptr;
  logic                  w_push;
  logic                  w_pop;

  // Extra pointer MSB separates full from empty when the indices coincide.
  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

  assign w_push = i_push & ~o_full;
  assign w_pop  = i_pop & ~o_empty;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
  end

  assign o_head = o_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];

endmodule

// File: rtl/pe_relay_nsew.sv
// Filler PE relaying NSEW channels through per-channel FIFOs, with straight
// or cross routing switched only once every FIFO has drained.
`timescale 1ns/1ps
module pe_relay_nsew
  import pe_relay_pkg::*;
#(
  parameter int DATA_WIDTH = 130,
  parameter int NUM_CH     = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         ap_start,
  input  logic                         mode,
  input  logic [NUM_CH*DATA_WIDTH-1:0] in_data,
  input  logic [NUM_CH-1:0]            in_valid,
  output logic [NUM_CH-1:0]            in_ready,
  output logic [NUM_CH*DATA_WIDTH-1:0] out_data,
  output logic [NUM_CH-1:0]            out_valid,
  input  logic [NUM_CH-1:0]            out_ready,
  output logic                         active_mode,
  output logic                         drain,
  output logic [CNT_WIDTH-1:0]         xfer_cnt
);

  state_t                r_state;
  state_t                w_state_nxt;
  logic                  r_active_mode;
  logic                  w_active_mode_nxt;
  logic                  r_drain;
  logic                  w_drain_nxt;
  logic [CNT_WIDTH-1:0]  r_xfer_cnt;

  logic [NUM_CH-1:0]     w_empty;
  logic [NUM_CH-1:0]     w_full;
  logic [NUM_CH-1:0]     w_push;
  logic [NUM_CH-1:0]     w_fifo_pop;
  logic [NUM_CH-1:0]     w_out_pop;
  logic [DATA_WIDTH-1:0] w_head [NUM_CH];
  logic                  w_accept;
  logic                  w_serve;
  logic                  w_cross;

  // Gating with ap_start keeps every handshake dead while the tile is paused.
  assign w_accept = ap_start & (r_state == RUN);
  assign w_serve  = ap_start & ((r_state == RUN) || (r_state == DRAIN));
  assign w_cross  = (r_active_mode == MODE_CROSS);

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    localparam int PAIR = g ^ 1;

    pe_relay_fifo #(
      .DATA_WIDTH (DATA_WIDTH),
      .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .i_push  (w_push[g]),
      .i_data  (in_data[g*DATA_WIDTH +: DATA_WIDTH]),
      .i_pop   (w_fifo_pop[g]),
      .o_head  (w_head[g]),
      .o_empty (w_empty[g]),
      .o_full  (w_full[g])
    );

    assign in_ready[g] = w_accept & ~w_full[g];
    assign w_push[g]   = in_valid[g] & in_ready[g];

    // Routing is an involution, so the FIFO feeding output g also drains into output g.
    assign out_valid[g] = w_serve & ~(w_cross ? w_empty[PAIR] : w_empty[g]);
    assign out_data[g*DATA_WIDTH +: DATA_WIDTH] = w_cross ? w_head[PAIR] : w_head[g];
    assign w_out_pop[g]  = out_valid[g] & out_ready[g];
    assign w_fifo_pop[g] = w_cross ? w_out_pop[PAIR] : w_out_pop[g];
  end

  always_comb begin
    w_state_nxt       = r_state;
    w_active_mode_nxt = r_active_mode;
    w_drain_nxt       = r_drain;
    unique case (r_state)
      IDLE: begin
        if (ap_start) w_state_nxt = r_drain ? DRAIN : RUN;
      end
      RUN: begin
        if (!ap_start) begin
          w_state_nxt = IDLE;
        end else if (mode != r_active_mode) begin
          w_state_nxt = DRAIN;
          w_drain_nxt = 1'b1;
        end
      end
      DRAIN: begin
        if (!ap_start) begin
          w_state_nxt = IDLE;
        end else if (&w_empty) begin
          w_state_nxt       = RUN;
          w_active_mode_nxt = mode;
          w_drain_nxt       = 1'b0;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= IDLE;
      r_active_mode <= MODE_STRAIGHT;
      r_drain       <= 1'b0;
      r_xfer_cnt    <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_active_mode <= w_active_mode_nxt;
      r_drain       <= w_drain_nxt;
      r_xfer_cnt    <= r_xfer_cnt + CNT_WIDTH'($countones(w_out_pop));
    end
  end

  assign active_mode = r_active_mode;
  assign drain       = r_drain;
  assign xfer_cnt    = r_xfer_cnt;

endmodule

// File: tb/tb_pe_relay_nsew.sv
// Scoreboard bench for pe_relay_nsew: directed pushes queue expected words per output.
`timescale 1ns/1ps
module tb_pe_relay_nsew;
  import pe_relay_pkg::*;

  localparam int DW = 130;
  localparam int NC = 4;
  localparam int FD = 4;
  localparam int CW = 16;

  logic            clk = 1'b0;
  logic            reset;
  logic            ap_start;
  logic            mode;
  logic [NC*DW-1:0] in_data;
  logic [NC-1:0]   in_valid;
  logic [NC-1:0]   in_ready;
  logic [NC*DW-1:0] out_data;
  logic [NC-1:0]   out_valid;
  logic [NC-1:0]   out_ready;
  logic            active_mode;
  logic            drain;
  logic [CW-1:0]   xfer_cnt;

  always #5 clk = ~clk;

  pe_relay_nsew #(
    .DATA_WIDTH (DW),
    .NUM_CH     (NC),
    .FIFO_DEPTH (FD),
    .CNT_WIDTH  (CW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .ap_start    (ap_start),
    .mode        (mode),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .active_mode (active_mode),
    .drain       (drain),
    .xfer_cnt    (xfer_cnt)
  );

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] exp_q [NC][$];
  logic [DW-1:0] pd [NC];
  logic [DW-1:0] e_mon;
  logic [NC-1:0] last_acc;
  logic          cross_exp = 1'b0;
  logic          sb_en     = 1'b1;
  logic          chk_bubble = 1'b0;
  int            acc_cnt = 0;
  int            bubbles = 0;

  function automatic logic [DW-1:0] od(input int j);
    return out_data[j*DW +: DW];
  endfunction

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Offer pd[] on channels in v for one cycle; accepted words are queued on their output.
  task automatic step(input logic [NC-1:0] v);
    for (int i = 0; i < NC; i++) in_data[i*DW +: DW] = pd[i];
    in_valid = v;
    @(negedge clk);
    if (chk_bubble && (out_valid != '1)) bubbles++;
    last_acc = v & in_ready;
    for (int i = 0; i < NC; i++) begin
      if (last_acc[i]) begin
        acc_cnt++;
        if (sb_en) exp_q[cross_exp ? (i ^ 1) : i].push_back(pd[i]);
      end
    end
    @(posedge clk);
    #1;
    in_valid = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) step('0);
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      for (int j = 0; j < NC; j++) begin
        if (out_valid[j] && out_ready[j]) begin
          if (exp_q[j].size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_out_ch%0d: got %0h want nothing", j, od(j));
          end else begin
            e_mon = exp_q[j].pop_front();
            chk($sformatf("out_ch%0d", j), od(j), e_mon);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int left;
    reset = 1'b1; ap_start = 1'b0; mode = MODE_STRAIGHT;
    in_valid = '0; in_data = '0; out_ready = '0;
    for (int i = 0; i < NC; i++) pd[i] = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_xfer", xfer_cnt, 0);
    chk("rst_active_mode", active_mode, 0);
    chk("rst_drain", drain, 0);

    reset = 1'b0; ap_start = 1'b1;
    @(posedge clk);
    #1;

    // single word latency on east
    out_ready = '1;
    pd[CH_EAST] = 130'h11;
    step(4'b0001);
    chk("t1_accept", last_acc, 4'b0001);
    chk("t1_out_valid", out_valid[0], 1'b1);
    chk("t1_out_data", od(0), 130'h11);
    idle(1);
    chk("t1_xfer", xfer_cnt, 1);

    // fill east under backpressure then release
    out_ready = '0;
    for (int k = 0; k < 4; k++) begin
      pd[CH_EAST] = DW'(8'hA0 + k);
      step(4'b0001);
      chk("t2_push_acc", last_acc[0], 1'b1);
    end
    chk("t2_full_ready", in_ready[0], 1'b0);
    pd[CH_EAST] = 130'hA4;
    step(4'b0001);
    chk("t2_full_reject", last_acc, 4'b0000);
    out_ready = '1;
    for (int k = 0; k < 4; k++) begin
      chk("t2_pop_valid", out_valid[0], 1'b1);
      idle(1);
    end
    chk("t2_empty_after", out_valid[0], 1'b0);
    chk("t2_xfer", xfer_cnt, 5);

    // four channels streaming 100 words each
    acc_cnt = 0; bubbles = 0;
    for (int k = 0; k < 100; k++) begin
      for (int c = 0; c < NC; c++)
        pd[c] = {2'(c), 64'hC0DE_0000_0000_0000 | 64'(k), 64'(k * 4 + c)};
      chk_bubble = (k >= 1);
      step('1);
    end
    chk_bubble = 1'b0;
    idle(2);
    chk("t3_accepted", acc_cnt, 400);
    chk("t3_bubbles", bubbles, 0);
    chk("t3_xfer", xfer_cnt, 405);

    // mode change with two words queued on north
    out_ready = '0;
    pd[CH_NORTH] = 130'h201; step(4'b0100);
    pd[CH_NORTH] = 130'h202; step(4'b0100);
    mode = MODE_CROSS;
    @(posedge clk);
    #1;
    chk("t4_drain_set", drain, 1'b1);
    chk("t4_drain_ready", in_ready, 0);
    chk("t4_mode_held", active_mode, 1'b0);
    out_ready = '1;
    n = 0;
    while (drain && n < 20) begin
      idle(1);
      n++;
    end
    chk("t4_drain_done", drain, 1'b0);
    chk("t4_active_mode", active_mode, 1'b1);
    cross_exp = 1'b1;
    pd[CH_EAST] = 130'h66; pd[CH_WEST] = 130'h55;
    step(4'b0011);
    chk("t4_cross_valid", out_valid[1:0], 2'b11);
    chk("t4_west_to_east", od(CH_EAST), 130'h55);
    chk("t4_east_to_west", od(CH_WEST), 130'h66);
    idle(1);
    chk("t4_xfer", xfer_cnt, 409);

    // pause with three words queued on south (routed to north)
    out_ready = '0;
    pd[CH_SOUTH] = 130'h301; step(4'b1000);
    pd[CH_SOUTH] = 130'h302; step(4'b1000);
    pd[CH_SOUTH] = 130'h303; step(4'b1000);
    chk("t5_head_before", od(CH_NORTH), 130'h301);
    ap_start = 1'b0;
    out_ready = '1;
    idle(3);
    chk("t5_hold_valid", out_valid, 0);
    chk("t5_hold_ready", in_ready, 0);
    chk("t5_hold_data", od(CH_NORTH), 130'h301);
    chk("t5_hold_xfer", xfer_cnt, 409);
    ap_start = 1'b1;
    @(posedge clk);
    #1;
    idle(4);
    chk("t5_resume_xfer", xfer_cnt, 412);

    // reset with FIFOs partly full
    out_ready = '0;
    sb_en = 1'b0;
    pd[CH_EAST] = 130'h601; pd[CH_WEST] = 130'h602;
    step(4'b0011);
    step(4'b0011);
    chk("t6_queued", out_valid, 4'b0011);
    reset = 1'b1;
    mode = MODE_STRAIGHT;
    @(posedge clk);
    #1;
    chk("t6_rst_out_valid", out_valid, 0);
    chk("t6_rst_in_ready", in_ready, 0);
    chk("t6_rst_xfer", xfer_cnt, 0);
    chk("t6_rst_active_mode", active_mode, 1'b0);
    chk("t6_rst_drain", drain, 1'b0);
    chk("t6_rst_out_data", out_data, 0);
    reset = 1'b0;
    sb_en = 1'b1;
    cross_exp = 1'b0;
    out_ready = '1;
    idle(3);
    chk("t6_post_empty", out_valid, 0);

    left = 0;
    for (int j = 0; j < NC; j++) left += exp_q[j].size();
    chk("sb_all_consumed", left, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
